// File: rtl/instruction_fetch_if.sv
// Fetch-to-decode handshake: head of the fetch buffer offered as {pc, instruction}
// under valid/ready. Fetch is the master, decode the slave.
interface instruction_fetch_if;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instruction;

  modport master (output if_valid, output if_pc, output if_instruction, input if_ready);
  modport slave  (input if_valid, input if_pc, input if_instruction, output if_ready);
endinterface

// File: rtl/instruction_fetch.sv
// Fetch unit: owns the PC, issues to a 1-cycle instruction memory and queues
// responses in a 2-entry buffer. Optional macro IFETCH_ALIGN_CHECK_EN enables misaligned-redirect faults.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [31:0]                imem_address,
  input  logic [31:0]                imem_instruction,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  instruction_fetch_if.master        dec,
  output logic                       fault
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] pc_req;
  logic        inflight;
  logic [31:0] tag;
  logic        v0, v1;
  logic [31:0] p0, i0, p1, i1;
  logic        n_v0, n_v1;
  logic [31:0] n_p0, n_i0, n_p1, n_i1;
  logic        pop, push, issue, faulted;
  logic [1:0]  occ;
  logic [31:0] target;

`ifdef IFETCH_ALIGN_CHECK_EN
  logic fault_q;
  assign faulted = fault_q;
  assign fault   = fault_q;
  assign target  = redirect_pc;
`else
  assign faulted = 1'b0;
  assign fault   = 1'b0;
  assign target  = redirect_pc & ~32'h0000_0003;
`endif

  assign pop  = v0 && dec.if_ready;
  assign push = inflight && !redirect_valid;
  // Buffered entries plus the one in flight must leave room after this cycle's pop.
  assign occ   = 2'(v0) + 2'(v1) + 2'(inflight);
  assign issue = !redirect_valid && !faulted && ({1'b0, occ} < (3'd2 + {2'b00, pop}));

  assign imem_address       = pc_req;
  assign dec.if_valid       = v0;
  assign dec.if_pc          = p0;
  assign dec.if_instruction = i0;

  // Shift-style FIFO: slot 0 is always the head and holds {0, NOP} when empty.
  always_comb begin
    n_v0 = v0;
    n_v1 = v1;
    n_p0 = p0;
    n_i0 = i0;
    n_p1 = p1;
    n_i1 = i1;
    if (pop) begin
      n_v0 = v1;
      n_p0 = v1 ? p1 : 32'h0;
      n_i0 = v1 ? i1 : NOP;
      n_v1 = 1'b0;
      n_p1 = 32'h0;
      n_i1 = NOP;
    end
    if (push) begin
      if (!n_v0) begin
        n_v0 = 1'b1;
        n_p0 = tag;
        n_i0 = imem_instruction;
      end else begin
        n_v1 = 1'b1;
        n_p1 = tag;
        n_i1 = imem_instruction;
      end
    end
    if (redirect_valid) begin
      n_v0 = 1'b0;
      n_v1 = 1'b0;
      n_p0 = 32'h0;
      n_i0 = NOP;
      n_p1 = 32'h0;
      n_i1 = NOP;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_req   <= RESET_PC;
      inflight <= 1'b0;
      tag      <= 32'h0;
      v0       <= 1'b0;
      v1       <= 1'b0;
      p0       <= 32'h0;
      i0       <= NOP;
      p1       <= 32'h0;
      i1       <= NOP;
    end else begin
      v0       <= n_v0;
      v1       <= n_v1;
      p0       <= n_p0;
      i0       <= n_i0;
      p1       <= n_p1;
      i1       <= n_i1;
      inflight <= issue;
      if (issue)
        tag <= pc_req;
      if (redirect_valid)
        pc_req <= target;
      else if (issue)
        pc_req <= pc_req + 32'd4;
    end
  end

`ifdef IFETCH_ALIGN_CHECK_EN
  // Sticky until the next redirect; an aligned redirect clears it and resumes fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      fault_q <= 1'b0;
    else if (redirect_valid)
      fault_q <= (redirect_pc[1:0] != 2'b00);
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: memory word k at address 4k is 32'h1000_0000+k,
// returned one cycle after the address is presented.
module tb_instruction_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fault;
  int          tests = 0;
  int          fails = 0;

  instruction_fetch_if dec();

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_address     (imem_address),
    .imem_instruction (imem_instruction),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .dec              (dec.master),
    .fault            (fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    imem_instruction <= 32'h1000_0000 + (imem_address >> 2);

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the first cycle after reset release (cycle 0).
  task automatic do_reset;
    rst = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    dec.if_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    dec.if_ready = 1'b1;
    #12;
    tests++; if (dec.if_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid got %b expected 0", dec.if_valid); end
    tests++; if (dec.if_pc !== 32'h0) begin fails++; $display("[TB] FAIL reset_pc got %h expected 00000000", dec.if_pc); end
    tests++; if (dec.if_instruction !== 32'h13) begin fails++; $display("[TB] FAIL reset_instr got %h expected 00000013", dec.if_instruction); end
    tests++; if (imem_address !== 32'h0) begin fails++; $display("[TB] FAIL reset_addr got %h expected 00000000", imem_address); end
    tests++; if (fault !== 1'b0) begin fails++; $display("[TB] FAIL reset_fault got %b expected 0", fault); end
  endtask

  task automatic test_stream;
    do_reset;
    step;
    tests++; if (dec.if_valid !== 1'b0) begin fails++; $display("[TB] FAIL stream_latency got valid=%b expected 0", dec.if_valid); end
    for (int k = 0; k < 4; k++) begin
      step;
      tests++; if (dec.if_valid !== 1'b1 || dec.if_pc !== 32'(4*k) || dec.if_instruction !== 32'h1000_0000 + 32'(k))
        begin fails++; $display("[TB] FAIL stream_head got v=%b pc=%h ins=%h expected v=1 pc=%h ins=%h", dec.if_valid, dec.if_pc, dec.if_instruction, 32'(4*k), 32'h1000_0000 + 32'(k)); end
      tests++; if (imem_address !== 32'(4*k + 8)) begin fails++; $display("[TB] FAIL stream_addr got %h expected %h", imem_address, 32'(4*k + 8)); end
    end
  endtask

  task automatic test_stall;
    do_reset;
    repeat (4) step;
    dec.if_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tests++; if (dec.if_valid !== 1'b1 || dec.if_pc !== 32'h8 || dec.if_instruction !== 32'h1000_0002)
        begin fails++; $display("[TB] FAIL stall_hold got v=%b pc=%h ins=%h expected v=1 pc=00000008 ins=10000002", dec.if_valid, dec.if_pc, dec.if_instruction); end
      tests++; if (imem_address !== 32'h10) begin fails++; $display("[TB] FAIL stall_addr got %h expected 00000010", imem_address); end
      step;
    end
    dec.if_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tests++; if (dec.if_valid !== 1'b1 || dec.if_pc !== 32'(8 + 4*k) || dec.if_instruction !== 32'h1000_0002 + 32'(k))
        begin fails++; $display("[TB] FAIL stall_release got v=%b pc=%h ins=%h expected v=1 pc=%h", dec.if_valid, dec.if_pc, dec.if_instruction, 32'(8 + 4*k)); end
      tests++; if (imem_address !== 32'(16 + 4*k)) begin fails++; $display("[TB] FAIL stall_resume_addr got %h expected %h", imem_address, 32'(16 + 4*k)); end
      step;
    end
  endtask

  task automatic test_redirect;
    do_reset;
    repeat (5) step;
    tests++; if (dec.if_pc !== 32'hC) begin fails++; $display("[TB] FAIL redir_pre_head got %h expected 0000000c", dec.if_pc); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    step;
    redirect_valid = 1'b0;
    tests++; if (dec.if_valid !== 1'b0 || imem_address !== 32'h40) begin fails++; $display("[TB] FAIL redir_n1 got v=%b addr=%h expected v=0 addr=00000040", dec.if_valid, imem_address); end
    step;
    tests++; if (dec.if_valid !== 1'b0) begin fails++; $display("[TB] FAIL redir_n2 got v=%b expected 0", dec.if_valid); end
    step;
    tests++; if (dec.if_valid !== 1'b1 || dec.if_pc !== 32'h40 || dec.if_instruction !== 32'h1000_0010)
      begin fails++; $display("[TB] FAIL redir_n3 got v=%b pc=%h ins=%h expected v=1 pc=00000040 ins=10000010", dec.if_valid, dec.if_pc, dec.if_instruction); end
    step;
    tests++; if (dec.if_pc !== 32'h44 || dec.if_instruction !== 32'h1000_0011) begin fails++; $display("[TB] FAIL redir_n4 got pc=%h ins=%h expected pc=00000044 ins=10000011", dec.if_pc, dec.if_instruction); end
  endtask

  task automatic test_wrap;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step;
    redirect_valid = 1'b0;
    tests++; if (imem_address !== 32'hFFFF_FFFC) begin fails++; $display("[TB] FAIL wrap_addr_n1 got %h expected fffffffc", imem_address); end
    step;
    tests++; if (imem_address !== 32'h0) begin fails++; $display("[TB] FAIL wrap_addr_n2 got %h expected 00000000", imem_address); end
    step;
    tests++; if (dec.if_valid !== 1'b1 || dec.if_pc !== 32'hFFFF_FFFC || dec.if_instruction !== 32'h4FFF_FFFF)
      begin fails++; $display("[TB] FAIL wrap_top got v=%b pc=%h ins=%h expected v=1 pc=fffffffc ins=4fffffff", dec.if_valid, dec.if_pc, dec.if_instruction); end
    step;
    tests++; if (dec.if_valid !== 1'b1 || dec.if_pc !== 32'h0 || dec.if_instruction !== 32'h1000_0000)
      begin fails++; $display("[TB] FAIL wrap_zero got v=%b pc=%h ins=%h expected v=1 pc=00000000 ins=10000000", dec.if_valid, dec.if_pc, dec.if_instruction); end
  endtask

  task automatic test_back_to_back;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    step;
    redirect_pc = 32'h200;
    step;
    redirect_valid = 1'b0;
    tests++; if (dec.if_valid !== 1'b0 || imem_address !== 32'h200) begin fails++; $display("[TB] FAIL b2b_n1 got v=%b addr=%h expected v=0 addr=00000200", dec.if_valid, imem_address); end
    step;
    tests++; if (dec.if_valid !== 1'b0) begin fails++; $display("[TB] FAIL b2b_n2 got v=%b expected 0", dec.if_valid); end
    step;
    tests++; if (dec.if_valid !== 1'b1 || dec.if_pc !== 32'h200 || dec.if_instruction !== 32'h1000_0080)
      begin fails++; $display("[TB] FAIL b2b_n3 got v=%b pc=%h ins=%h expected v=1 pc=00000200 ins=10000080", dec.if_valid, dec.if_pc, dec.if_instruction); end
  endtask

  task automatic test_async_reset;
    do_reset;
    repeat (4) step;
    dec.if_ready = 1'b0;
    step;
    step;
    #2;
    rst = 1'b0;
    #1;
    tests++; if (dec.if_valid !== 1'b0 || dec.if_instruction !== 32'h13 || dec.if_pc !== 32'h0 || imem_address !== 32'h0)
      begin fails++; $display("[TB] FAIL async_reset got v=%b pc=%h ins=%h addr=%h expected v=0 pc=0 ins=13 addr=0", dec.if_valid, dec.if_pc, dec.if_instruction, imem_address); end
  endtask

  task automatic test_misaligned;
    do_reset;
    repeat (3) step;
    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    step;
    redirect_valid = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
    tests++; if (fault !== 1'b1 || imem_address !== 32'h42) begin fails++; $display("[TB] FAIL align_fault got f=%b addr=%h expected f=1 addr=00000042", fault, imem_address); end
    for (int c = 0; c < 10; c++) begin
      tests++; if (dec.if_valid !== 1'b0 || fault !== 1'b1) begin fails++; $display("[TB] FAIL align_blocked got v=%b f=%b expected v=0 f=1", dec.if_valid, fault); end
      step;
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    step;
    redirect_valid = 1'b0;
    tests++; if (fault !== 1'b0) begin fails++; $display("[TB] FAIL align_clear got f=%b expected 0", fault); end
    step;
    step;
    tests++; if (dec.if_valid !== 1'b1 || dec.if_pc !== 32'h80) begin fails++; $display("[TB] FAIL align_resume got v=%b pc=%h expected v=1 pc=00000080", dec.if_valid, dec.if_pc); end
`else
    tests++; if (fault !== 1'b0 || imem_address !== 32'h40) begin fails++; $display("[TB] FAIL align_force got f=%b addr=%h expected f=0 addr=00000040", fault, imem_address); end
    step;
    step;
    tests++; if (dec.if_valid !== 1'b1 || dec.if_pc !== 32'h40 || dec.if_instruction !== 32'h1000_0010)
      begin fails++; $display("[TB] FAIL align_force_head got v=%b pc=%h ins=%h expected v=1 pc=00000040 ins=10000010", dec.if_valid, dec.if_pc, dec.if_instruction); end
`endif
  endtask

  initial begin
    dec.if_ready = 1'b1;
    test_reset;
    test_stream;
    test_stall;
    test_redirect;
    test_wrap;
    test_back_to_back;
    test_async_reset;
    test_misaligned;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch-side initiator for `instruction_memory`: owns the program counter, drives the memory address, captures the returned word and hands `{pc, instruction}` to decode over a valid/ready handshake. It sits between `instruction_memory` and the decode stage of the single-core RV32I pipeline. It also absorbs decode stalls with a 2-entry buffer and handles branch/jump redirects by discarding stale fetches.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `imem_address`  out  32  address to `instruction_memory`.
- `imem_instruction`  in  32  word for the address presented the previous cycle (1-cycle synchronous read).
- `redirect_valid`  in  1  branch/jump taken this cycle.
- `redirect_pc`  in  32  redirect target.
- `if_valid`  out  1  buffer head valid.
- `if_ready`  in  1  decode accepts head.
- `if_pc`  out  32  PC of head.
- `if_instruction`  out  32  instruction of head.
- `fault`  out  1  misaligned redirect (see Configuration).

## Operation
- `pc_req` register drives `imem_address` directly.
- Buffer: 2-entry FIFO of `{pc, instr}`. `count` is 0..2. `inflight` is 1 bit: a request was issued last cycle.
- Pop: `if_valid && if_ready`.
- Issue in a cycle when `count + inflight - pop < 2`, and no redirect, and not faulted.
  - On issue: `inflight` is set for the next cycle with tag `pc_req`, and `pc_req <= pc_req + 4`.
  - The add is 32-bit modular: 0xFFFF_FFFC wraps to 0x0000_0000.
- Capture: in a cycle with `inflight=1` and the request not killed, `{tag, imem_instruction}` is pushed at the clock edge that ends that cycle.
- Credit rule guarantees there is never a push into a full buffer. A push/pop in the same cycle leaves `count` unchanged.
- Outputs come from the buffer head, registered. When `count=0`: `if_pc=0`, `if_instruction=32'h0000_0013` (NOP).
- Redirect, edge at end of cycle N:
  - Buffer cleared, and any in-flight response is killed (never pushed).
  - `pc_req <= redirect_pc`.
  - A pop in cycle N still counts as accepted.
  - Redirect overrides issue.
- Reset overrides redirect.
- Reset (async assert, any time):
  - `pc_req=RESET_PC`, `count=0`, `inflight=0`, `fault=0`.
  - `if_valid=0`, `if_pc=0`, `if_instruction=32'h0000_0013`.
  - `imem_address=RESET_PC`.
  - Outputs change without waiting for a clock edge.

## Timing
- Address→visible latency: 2 cycles. Address is presented in cycle t, data is valid in t+1, and `if_valid` asserts in t+2.
- First cycle after reset release issues `RESET_PC`; the first `if_valid` is 2 cycles later.
- Throughput: 1 instruction/cycle with `if_ready` held high; steady state is `count=1`, `inflight=1`.
- Stall: at most 2 entries are held; `imem_address` freezes once credits run out. No drops or duplicates. The head holds stable while `if_valid && !if_ready`.
- Redirect in cycle N:
  - `imem_address = redirect_pc` in N+1.
  - `if_valid=0` in N+1 and N+2.
  - First valid target entry in N+3.
- Back-to-back redirects: the last one wins; each one flushes.

## Configuration
- Macro `IFETCH_ALIGN_CHECK_EN`.
- Defined:
  - A redirect with `redirect_pc[1:0] != 0` flushes as usual but sets sticky `fault=1`.
  - `pc_req` loads the target anyway, but issue is blocked, so `if_valid` stays 0.
  - `fault` clears on the next aligned redirect (which resumes fetch) or on reset.
- Undefined:
  - `redirect_pc[1:0]` is forced to 2'b00 on load.
  - `fault` is tied 0.
  - The port exists in both builds.

## Test plan
- Reset release, `RESET_PC=0`, memory word k = 32'h1000_0000+k, `if_ready=1` → `if_valid` rises 2 cycles after release; `if_pc` is 0,4,8,12 on consecutive cycles with matching words.
- Hold `if_ready=0` for 4 cycles while head `if_pc=8` → head holds 8/0x1000_0002 and `imem_address` stops advancing. After release: 8,12,16 with no gap, no drop, no duplicate.
- Redirect to 0x40 while head is 0xC → `if_valid=0` for 2 cycles; next valid `if_pc=0x40`; 0x10 and 0x14 are never presented.
- Redirect to 0xFFFF_FFFC → `if_pc` sequence 0xFFFF_FFFC, 0x0000_0000.
- Assert `rst=0` mid-stall between clock edges → `if_valid=0`, `if_instruction=0x13`, `imem_address=RESET_PC` immediately.
- With `IFETCH_ALIGN_CHECK_EN`: redirect 0x42 → `fault=1`, `if_valid=0` for 10 cycles. Then redirect 0x80 → `fault=0`, `if_pc=0x80` 3 cycles later.
